// File: rtl/pixel_window_pkg.sv
// Shared constants, pixel type and width helper for the 3x3 RGB window builder.
package pixel_window_pkg;

  localparam int WIN_PIXELS  = 32'sd9;
  localparam int WIN_DIM     = 32'sd3;
  localparam int CENTER_IDX  = 32'sd4;
  localparam int DEFAULT_BPP = 32'sd8;

  typedef struct packed {
    logic [DEFAULT_BPP-1:0] red;
    logic [DEFAULT_BPP-1:0] green;
    logic [DEFAULT_BPP-1:0] blue;
  } rgb_t;

  function automatic int rgb_w(input int bpp);
    return 32'sd3 * bpp;
  endfunction

endpackage

// File: rtl/pixel_line_buffer.sv
// Two-line RGB history: one word per column holding {line r-2, line r-1}.
// Shared address for the write port and the asynchronous read port.
module pixel_line_buffer #(
  parameter int DEPTH = 32'sd640,
  parameter int WIDTH = 32'sd48
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Column word update on each accepted pixel; the storage itself has no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[addr];

endmodule

// File: rtl/pixel_window_builder.sv
// Raster RGB pixel stream in, interior 3x3 windows out (row-major, k = 3*dr + dc).
// Optional sticky frame_err output is built when PIXEL_WINDOW_FRAME_ERR_EN is defined.
module pixel_window_builder
  import pixel_window_pkg::*;
#(
  parameter int BIT_PER_PIXEL = 32'sd8,
  parameter int IMG_WIDTH     = 32'sd640,
  parameter int IMG_HEIGHT    = 32'sd480
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_sof,
  input  logic [BIT_PER_PIXEL-1:0]            in_red,
  input  logic [BIT_PER_PIXEL-1:0]            in_green,
  input  logic [BIT_PER_PIXEL-1:0]            in_blue,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIN_PIXELS*BIT_PER_PIXEL-1:0] win_red,
  output logic [WIN_PIXELS*BIT_PER_PIXEL-1:0] win_green,
  output logic [WIN_PIXELS*BIT_PER_PIXEL-1:0] win_blue
`ifdef PIXEL_WINDOW_FRAME_ERR_EN
  ,
  output logic                                frame_err
`endif
);

  localparam int RGB_W = rgb_w(BIT_PER_PIXEL);
  localparam int WIN_W = WIN_PIXELS * BIT_PER_PIXEL;
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 32'sd1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 32'sd1);
  localparam logic [CW-1:0] COL_FIRST = CW'(WIN_DIM - 32'sd1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(WIN_DIM - 32'sd1);
  localparam logic [CW-1:0] COL_INC   = CW'(32'sd1);
  localparam logic [RW-1:0] ROW_INC   = RW'(32'sd1);

  typedef struct packed {
    logic [BIT_PER_PIXEL-1:0] red;
    logic [BIT_PER_PIXEL-1:0] green;
    logic [BIT_PER_PIXEL-1:0] blue;
  } pix_t;

  logic             accept_s;
  logic             emit_s;
  logic [CW-1:0]    col_r;
  logic [CW-1:0]    col_s;
  logic [CW-1:0]    col_next_s;
  logic [RW-1:0]    row_r;
  logic [RW-1:0]    row_s;
  logic [RW-1:0]    row_next_s;
  pix_t             cur_s;
  pix_t             above2_s;
  pix_t             above1_s;
  logic [2*RGB_W-1:0] rd_word_s;
  logic [2*RGB_W-1:0] wr_word_s;
  pix_t             win_r      [WIN_DIM][WIN_DIM];
  pix_t             win_next_s [WIN_DIM][WIN_DIM];
  logic [WIN_W-1:0] pack_red_s;
  logic [WIN_W-1:0] pack_green_s;
  logic [WIN_W-1:0] pack_blue_s;
  logic             out_valid_r;
  logic [WIN_W-1:0] win_red_r;
  logic [WIN_W-1:0] win_green_r;
  logic [WIN_W-1:0] win_blue_r;

  assign in_ready  = !out_valid_r || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign cur_s     = {in_red, in_green, in_blue};

  // An accepted start-of-frame overrides the counters, so the pixel lands at (0,0).
  assign col_s     = in_sof ? {CW{1'b0}} : col_r;
  assign row_s     = in_sof ? {RW{1'b0}} : row_r;
  assign emit_s    = accept_s && (row_s >= ROW_FIRST) && (col_s >= COL_FIRST);

  assign above2_s  = pix_t'(rd_word_s[2*RGB_W-1:RGB_W]);
  assign above1_s  = pix_t'(rd_word_s[RGB_W-1:0]);
  assign wr_word_s = {above1_s, cur_s};

  pixel_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (2*RGB_W)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (accept_s),
    .addr    (col_s),
    .wr_data (wr_word_s),
    .rd_data (rd_word_s)
  );

  // Raster position advance with line and frame wrap.
  always_comb begin
    col_next_s = col_s;
    row_next_s = row_s;
    if (col_s == COL_LAST) begin
      col_next_s = {CW{1'b0}};
      if (row_s == ROW_LAST) begin
        row_next_s = {RW{1'b0}};
      end else begin
        row_next_s = row_s + ROW_INC;
      end
    end else begin
      col_next_s = col_s + COL_INC;
    end
  end

  // Shift the window left and bring in the new right column {r-2, r-1, current}.
  always_comb begin
    win_next_s = win_r;
    for (int dr = 0; dr < WIN_DIM; dr++) begin
      for (int dc = 0; dc < WIN_DIM - 1; dc++) begin
        win_next_s[dr][dc] = win_r[dr][dc+1];
      end
    end
    win_next_s[0][WIN_DIM-1] = above2_s;
    win_next_s[1][WIN_DIM-1] = above1_s;
    win_next_s[2][WIN_DIM-1] = cur_s;
  end

  // Flatten the updated window into the per-channel output buses.
  always_comb begin
    pack_red_s   = {WIN_W{1'b0}};
    pack_green_s = {WIN_W{1'b0}};
    pack_blue_s  = {WIN_W{1'b0}};
    for (int dr = 0; dr < WIN_DIM; dr++) begin
      for (int dc = 0; dc < WIN_DIM; dc++) begin
        pack_red_s  [(dr*WIN_DIM + dc)*BIT_PER_PIXEL +: BIT_PER_PIXEL] = win_next_s[dr][dc].red;
        pack_green_s[(dr*WIN_DIM + dc)*BIT_PER_PIXEL +: BIT_PER_PIXEL] = win_next_s[dr][dc].green;
        pack_blue_s [(dr*WIN_DIM + dc)*BIT_PER_PIXEL +: BIT_PER_PIXEL] = win_next_s[dr][dc].blue;
      end
    end
  end

  // Raster position counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (accept_s) begin
      col_r <= col_next_s;
      row_r <= row_next_s;
    end
  end

  // 3x3 neighbourhood shift registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int dr = 0; dr < WIN_DIM; dr++) begin
        for (int dc = 0; dc < WIN_DIM; dc++) begin
          win_r[dr][dc] <= {RGB_W{1'b0}};
        end
      end
    end else if (accept_s) begin
      win_r <= win_next_s;
    end
  end

  // Presented window: a fresh load wins over a consumed one, giving one window per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      win_red_r   <= {WIN_W{1'b0}};
      win_green_r <= {WIN_W{1'b0}};
      win_blue_r  <= {WIN_W{1'b0}};
    end else if (emit_s) begin
      out_valid_r <= 1'b1;
      win_red_r   <= pack_red_s;
      win_green_r <= pack_green_s;
      win_blue_r  <= pack_blue_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign win_red   = win_red_r;
  assign win_green = win_green_r;
  assign win_blue  = win_blue_r;

`ifdef PIXEL_WINDOW_FRAME_ERR_EN
  logic frame_err_r;

  // Sticky: start-of-frame accepted anywhere but the expected origin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err_r <= 1'b0;
    end else if (accept_s && in_sof && ((col_r != {CW{1'b0}}) || (row_r != {RW{1'b0}}))) begin
      frame_err_r <= 1'b1;
    end
  end

  assign frame_err = frame_err_r;
`endif

endmodule

// File: tb/tb_pixel_window_builder.sv
// Scoreboard bench for pixel_window_builder on a 4x4 image: reference windows come from a frame image model.
module tb_pixel_window_builder;

  localparam int BPP = 8;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int WB  = 9 * BPP;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic           in_sof;
  logic [BPP-1:0] in_red;
  logic [BPP-1:0] in_green;
  logic [BPP-1:0] in_blue;
  logic           out_valid;
  logic           out_ready;
  logic [WB-1:0]  win_red;
  logic [WB-1:0]  win_green;
  logic [WB-1:0]  win_blue;
`ifdef PIXEL_WINDOW_FRAME_ERR_EN
  logic           frame_err;
`endif

  typedef struct packed {
    logic [BPP-1:0] r;
    logic [BPP-1:0] g;
    logic [BPP-1:0] b;
  } px_t;

  typedef struct {
    logic [WB-1:0] r;
    logic [WB-1:0] g;
    logic [WB-1:0] b;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  px_t  img [H][W];
  int   mr = 0;
  int   mc = 0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   win_cnt = 0;
  bit   rand_ready = 1'b0;

  pixel_window_builder #(
    .BIT_PER_PIXEL (BPP),
    .IMG_WIDTH     (W),
    .IMG_HEIGHT    (H)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_red    (in_red),
    .in_green  (in_green),
    .in_blue   (in_blue),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .win_red   (win_red),
    .win_green (win_green),
    .win_blue  (win_blue)
`ifdef PIXEL_WINDOW_FRAME_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, want %0h", name, act, req);
  endtask

  function automatic px_t spx(input int r, input int c);
    logic [BPP-1:0] v;
    v = 8'(r * 16 + c);
    return {v, ~v, 8'(c)};
  endfunction

  // Reference: remember the frame, and every interior pixel yields the window ending at it.
  function automatic void model_accept(input px_t p, input logic sof);
    exp_t e;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = p;
    if (mr >= 2 && mc >= 2) begin
      for (int k = 0; k < 9; k++) begin
        px_t q;
        q = img[mr - 2 + k / 3][mc - 2 + k % 3];
        e.r[k*BPP +: BPP] = q.r;
        e.g[k*BPP +: BPP] = q.g;
        e.b[k*BPP +: BPP] = q.b;
      end
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr + 1) % H;
    end
  endfunction

  task automatic send(input px_t p, input logic sof);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_red   = p.r;
    in_green = p.g;
    in_blue  = p.b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(p, sof);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    chk("send_accept", 72'(done), 72'd1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input bit sof0, input bit rnd, input int gap_max);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        px_t p;
        if (rnd) p = 24'($urandom);
        else     p = spx(r, c);
        send(p, sof0 && r == 0 && c == 0);
        if (gap_max > 0) begin
          repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
          end
        end
      end
    end
  endtask

  task automatic drain(input string name, input int want);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_idle"}, 72'(exp_q.size() == 0 && !out_valid), 72'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_count"}, 72'(win_cnt), 72'(want));
    win_cnt = 0;
  endtask

  task automatic hold_check();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("bp_window_seen", 72'(out_valid), 72'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_in_ready", 72'(in_ready), 72'd0);
      chk("bp_out_valid", 72'(out_valid), 72'd1);
      if (exp_q.size() > 0) begin
        chk("bp_hold_red", win_red, exp_q[0].r);
        chk("bp_hold_green", win_green, exp_q[0].g);
        chk("bp_hold_blue", win_blue, exp_q[0].b);
      end else begin
        chk("bp_queue_len", 72'(exp_q.size()), 72'd1);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  // Monitor: latency on each newly presented window, content on each handshake.
  initial begin
    bit fresh;
    fresh = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        fresh = 1'b1;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_window", 72'(exp_q.size()), 72'd1);
        end else begin
          if (fresh) chk("latency", 72'(cyc), 72'(exp_q[0].cyc));
          if (out_ready) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("win_red", win_red, e.r);
            chk("win_green", win_green, e.g);
            chk("win_blue", win_blue, e.b);
            win_cnt++;
          end
        end
        fresh = out_ready;
      end else begin
        fresh = 1'b1;
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_red    = '0;
    in_green  = '0;
    in_blue   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 72'(out_valid), 72'd0);
    chk("rst_win_red", win_red, 72'd0);
    chk("rst_win_green", win_green, 72'd0);
    chk("rst_win_blue", win_blue, 72'd0);
    chk("rst_in_ready", 72'(in_ready), 72'd1);
`ifdef PIXEL_WINDOW_FRAME_ERR_EN
    chk("rst_frame_err", 72'(frame_err), 72'd0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    send_frame(1'b1, 1'b0, 0);
    drain("full", 4);

    out_ready = 1'b0;
    fork
      send_frame(1'b1, 1'b0, 0);
      hold_check();
    join
    drain("backpressure", 4);

    for (int i = 0; i < W + 3; i++) send(spx(i / W, i % W), i == 0);
    send_frame(1'b1, 1'b0, 0);
    drain("resync", 4);
`ifdef PIXEL_WINDOW_FRAME_ERR_EN
    chk("resync_frame_err", 72'(frame_err), 72'd1);
`endif

    for (int i = 0; i < 2 * W + 2; i++) send(spx(i / W, i % W), i == 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 72'(out_valid), 72'd0);
    chk("midrst_win_red", win_red, 72'd0);
    chk("midrst_in_ready", 72'(in_ready), 72'd1);
`ifdef PIXEL_WINDOW_FRAME_ERR_EN
    chk("midrst_frame_err", 72'(frame_err), 72'd0);
`endif
    exp_q.delete();
    mr = 0;
    mc = 0;
    win_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_frame(1'b0, 1'b0, 0);
    drain("after_reset", 4);

    send_frame(1'b1, 1'b0, 0);
    send_frame(1'b1, 1'b0, 0);
    drain("back_to_back", 8);

    rand_ready = 1'b1;
    repeat (3) send_frame(1'b1, 1'b1, 2);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain("random", 12);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
